// File: rtl/add_out_responder.sv
// Operand-pair adder responder: valid/ready input, two-stage add pipeline,
// credit-controlled first-word-fall-through result FIFO, valid/ready output.
module add_out_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_sum,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_valid;
  logic [DATA_WIDTH:0]   s2_sum;
  logic [TAG_WIDTH-1:0]  s2_tag;

  logic [TAG_WIDTH-1:0]  tag_reg;

  logic [DATA_WIDTH:0]   mem_sum [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [PW+1:0]         occupancy;

  logic accept;
  logic push;
  logic pop;

  // Every accepted pair holds a credit from acceptance until it is popped,
  // so the pipeline can always drain into the FIFO without stalling.
  assign occupancy = {1'b0, count}
                   + {{(PW+1){1'b0}}, s1_valid}
                   + {{(PW+1){1'b0}}, s2_valid};

  assign in_ready  = !reset && (occupancy < (PW+2)'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = s2_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = s1_valid || s2_valid || (count != '0);

  // Head is presented only while valid so the outputs read zero when empty.
  assign out_sum = out_valid ? mem_sum[rd_ptr] : '0;
  assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_tag   <= '0;
      tag_reg  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_tag  <= tag_reg;
        tag_reg <= tag_reg + TAG_WIDTH'(1);
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum <= {1'b0, s1_a} + {1'b0, s1_b};
        s2_tag <= s1_tag;
      end

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_sum[wr_ptr] <= s2_sum;
      mem_tag[wr_ptr] <= s2_tag;
    end
  end

endmodule

// File: tb/tb_add_out_responder.sv
// Directed bench for add_out_responder: a cycle-accurate scoreboard checks
// latency, ordering, tags, sums, credits and busy on every cycle.
module tb_add_out_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic [3:0] out_tag;
  logic       busy;

  add_out_responder #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .TAG_WIDTH (4)
  ) dut (
    .clock    (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sum;
    logic [3:0] tag;
    int         vis;
  } exp_t;

  exp_t       q[$];
  logic [3:0] tag_m = '0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: an accepted pair becomes visible at the head after the
  // second edge following the accept edge.
  always @(negedge clk) begin
    logic exp_ov;
    exp_t e;
    if (reset) begin
      q.delete();
      tag_m = '0;
      chk("in_ready_in_reset", 32'(in_ready), 32'd0);
    end else begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].vis);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("in_ready_credit", 32'(in_ready), 32'(q.size() < 4));
      if (out_valid && exp_ov) begin
        chk("out_sum", 32'(out_sum), 32'(q[0].sum));
        chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        e.sum = {1'b0, in_a} + {1'b0, in_b};
        e.tag = tag_m;
        e.vis = cyc + 3;
        q.push_back(e);
        tag_m = tag_m + 4'd1;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n_acc;
    logic acc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Single op: exactly two cycles from the accept edge to out_valid.
    send(8'h12, 8'h34);
    @(negedge clk);
    chk("lat_e0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_e2", 32'(out_valid), 32'd1);
    chk("single_sum", 32'(out_sum), 32'h046);
    chk("single_tag", 32'(out_tag), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Carry and extremes.
    send(8'hFF, 8'hFF);
    send(8'hFF, 8'h01);
    send(8'h00, 8'h00);
    drain();

    // Backpressure: only four credits exist.
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1;
    in_a = 8'h10;
    in_b = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        in_a = in_a + 8'h10;
        in_b = in_b + 8'h01;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepts", 32'(n_acc), 32'd4);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Streaming back-to-back; the tag counter wraps along the way.
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain();

    // Random output backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    // Reset with results queued and in flight.
    out_ready = 1'b0;
    send(8'h01, 8'h02);
    send(8'h03, 8'h04);
    send(8'h05, 8'h06);
    send(8'h07, 8'h08);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h05, 8'h06);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_tag", 32'(out_tag), 32'd0);
    chk("post_rst_sum", 32'(out_sum), 32'h00B);
    @(posedge clk);
    #1;
    drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
